// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding modes, fflags bit positions and per-width
// IEEE-754 field sizes, used by both the int-to-float and float-to-int converters.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // fflags = {NV, DZ, OF, UF, NX}
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  localparam int MANTISSA_SIZE_32 = 23;
  localparam int EXPONENT_SIZE_32 = 8;
  localparam int BIAS_32          = 127;
  localparam int MANTISSA_SIZE_64 = 52;
  localparam int EXPONENT_SIZE_64 = 11;
  localparam int BIAS_64          = 1023;

  function automatic int mantissa_size(input int bus_width);
    return (bus_width == 32) ? MANTISSA_SIZE_32 : MANTISSA_SIZE_64;
  endfunction

  function automatic int exponent_size(input int bus_width);
    return (bus_width == 32) ? EXPONENT_SIZE_32 : EXPONENT_SIZE_64;
  endfunction

  function automatic int exponent_bias(input int bus_width);
    return (bus_width == 32) ? BIAS_32 : BIAS_64;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parameterized leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(WIDTH):0]   cnt_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // NOTE: the output gets a default before the loop, so every path assigns it
  // and no latch is inferred.
  always_comb begin
    cnt_o = CW'(WIDTH);
    // Scanning upward lets the highest set bit take the last assignment.
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fcvt_int_to_fp_pipe.sv
// Three-stage integer-to-float converter (FCVT.S/D.W/WU/L/LU): capture/negate,
// normalize, round/pack, with a single pipeline-wide valid/ready enable.
module fcvt_int_to_fp_pipe
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] int_in,
  input  logic                 is_signed,
  input  logic [2:0]           rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] fp_out,
  output logic [4:0]           fflags
);

  localparam int MANT = mantissa_size(BUS_WIDTH);
  localparam int EXPW = exponent_size(BUS_WIDTH);
  localparam int BIAS = exponent_bias(BUS_WIDTH);
  localparam int LZW  = $clog2(BUS_WIDTH) + 1;

  logic en;

  // Stage 1: sign and magnitude
  logic                 s1_valid_q;
  logic                 s1_sign_d,  s1_sign_q;
  logic [BUS_WIDTH-1:0] s1_mag_d,   s1_mag_q;
  logic [2:0]           s1_rm_q;
  logic                 s1_zero_d,  s1_zero_q;

  // Stage 2: normalized mantissa (hidden one dropped) and biased exponent
  logic                 s2_valid_q;
  logic                 s2_sign_q;
  logic [LZW-1:0]       s2_lz;
  logic [BUS_WIDTH-1:0] s2_norm_full;
  logic [BUS_WIDTH-2:0] s2_norm_q;
  // BIAS + BUS_WIDTH - 1, even after a rounding carry, fits in EXPW bits.
  logic [EXPW-1:0]      s2_exp_d,   s2_exp_q;
  logic [2:0]           s2_rm_q;
  logic                 s2_zero_q;

  // Stage 3: rounding and packing
  logic                 s3_valid_q;
  logic [MANT-1:0]      s3_frac;
  logic                 s3_guard, s3_sticky, s3_inc, s3_carry;
  logic [MANT-1:0]      s3_frac_rnd;
  logic [EXPW-1:0]      s3_exp_rnd;
  logic [BUS_WIDTH-1:0] s3_res_d,   s3_res_q;
  logic                 s3_nx_d,    s3_nx_q;

  assign en       = ~s3_valid_q | out_ready;
  assign in_ready = en;

  // S1: the most negative operand negates to 2^(BUS_WIDTH-1), still correct unsigned.
  always_comb begin
    s1_sign_d = is_signed & int_in[BUS_WIDTH-1];
    s1_mag_d  = s1_sign_d ? (~int_in + BUS_WIDTH'(1)) : int_in;
    s1_zero_d = (int_in == '0);
  end

  // S2
  fpu_lzc #(
    .WIDTH (BUS_WIDTH)
  ) u_lzc (
    .data_i (s1_mag_q),
    .cnt_o  (s2_lz)
  );

  always_comb begin
    s2_norm_full = s1_mag_q << s2_lz;
    s2_exp_d     = EXPW'(BIAS + BUS_WIDTH - 1) - EXPW'(s2_lz);
  end

  // S3
  always_comb begin
    s3_frac   = s2_norm_q[BUS_WIDTH-2 -: MANT];
    s3_guard  = s2_norm_q[BUS_WIDTH-2-MANT];
    s3_sticky = |s2_norm_q[BUS_WIDTH-3-MANT:0];

    unique case (s2_rm_q)
      RM_RNE:  s3_inc = s3_guard & (s3_sticky | s3_frac[0]);
      RM_RTZ:  s3_inc = 1'b0;
      RM_RDN:  s3_inc = s2_sign_q & (s3_guard | s3_sticky);
      RM_RUP:  s3_inc = ~s2_sign_q & (s3_guard | s3_sticky);
      RM_RMM:  s3_inc = s3_guard;
      default: s3_inc = s3_guard & (s3_sticky | s3_frac[0]);
    endcase

    // A carry out leaves the fraction at zero and bumps the exponent.
    {s3_carry, s3_frac_rnd} = {1'b0, s3_frac} + (MANT+1)'(s3_inc);
    s3_exp_rnd = s2_exp_q + EXPW'(s3_carry);

    // Zero converts to +0 in every mode and is exact.
    s3_res_d = s2_zero_q ? '0 : {s2_sign_q, s3_exp_rnd, s3_frac_rnd};
    s3_nx_d  = ~s2_zero_q & (s3_guard | s3_sticky);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
    end
  end

  // NOTE: data registers are left unreset; they are only observed behind
  // their stage valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_rm_q   <= rm;
      s1_zero_q <= s1_zero_d;

      s2_sign_q <= s1_sign_q;
      s2_norm_q <= s2_norm_full[BUS_WIDTH-2:0];
      s2_exp_q  <= s2_exp_d;
      s2_rm_q   <= s1_rm_q;
      s2_zero_q <= s1_zero_q;

      s3_res_q  <= s3_res_d;
      s3_nx_q   <= s3_nx_d;
    end
  end

  // Outputs read zero whenever no result is presented.
  always_comb begin
    out_valid        = s3_valid_q;
    fp_out           = s3_valid_q ? s3_res_q : '0;
    fflags           = '0;
    fflags[FFLAG_NX] = s3_valid_q & s3_nx_q;
  end

endmodule

// File: tb/tb_fcvt_int_to_fp_pipe.sv
// Bench for fcvt_int_to_fp_pipe: 64- and 32-bit instances checked against an
// arithmetic rounding model, with directed, random, backpressure and reset cases.
module tb_fcvt_int_to_fp_pipe;

  typedef struct packed {
    logic [63:0] res;
    logic        nx;
  } exp_t;

  typedef struct {
    int          d;
    logic [63:0] v;
    bit          sgn;
    logic [2:0]  m;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [63:0] int_in    [2];
  logic        is_signed;
  logic [2:0]  rm;
  logic        out_ready;
  logic        ov        [2];
  logic [63:0] fp        [2];
  logic [4:0]  ff        [2];
  logic [31:0] fp32;

  exp_t        q         [2][$];
  int          n_checks = 0;
  int          n_errors = 0;

  bit          hold_v    [2];
  logic [63:0] hold_fp   [2];
  logic [4:0]  hold_ff   [2];

  fcvt_int_to_fp_pipe #(.BUS_WIDTH(64)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .int_in    (int_in[0]),
    .is_signed (is_signed),
    .rm        (rm),
    .out_valid (ov[0]),
    .out_ready (out_ready),
    .fp_out    (fp[0]),
    .fflags    (ff[0])
  );

  fcvt_int_to_fp_pipe #(.BUS_WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .int_in    (int_in[1][31:0]),
    .is_signed (is_signed),
    .rm        (rm),
    .out_valid (ov[1]),
    .out_ready (out_ready),
    .fp_out    (fp32),
    .fflags    (ff[1])
  );

  assign fp[1] = {32'd0, fp32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Exact arithmetic model: round by comparing the discarded remainder with one half.
  function automatic exp_t model(input bit w32, input logic [63:0] v, input bit sgn,
                                 input logic [2:0] m);
    int          w, mb, e, p, sh;
    logic [63:0] mask, x, mag, kept, rem, half, frac;
    bit          s, up;
    exp_t        r;
    w    = w32 ? 32 : 64;
    mb   = w32 ? 23 : 52;
    mask = w32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    x    = v & mask;
    s    = sgn && x[w-1];
    mag  = s ? ((~x + 64'd1) & mask) : x;
    r.res = '0;
    r.nx  = 1'b0;
    if (mag == 0) return r;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e = (w32 ? 127 : 1023) + p;
    if (p <= mb) begin
      kept = mag << (mb - p);
      rem  = 0;
      half = 0;
    end else begin
      sh   = p - mb;
      kept = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = (rem != 0) && (rem >= half);
      default: up = (rem != 0) && ((rem > half) || ((rem == half) && kept[0]));
    endcase
    kept = kept + 64'(up);
    if (kept == (64'd1 << (mb + 1))) begin
      kept = kept >> 1;
      e++;
    end
    frac = kept & ((64'd1 << mb) - 64'd1);
    r.nx = (rem != 0);
    if (w32) r.res = {32'd0, s, e[7:0], frac[22:0]};
    else     r.res = {s, e[10:0], frac[51:0]};
    return r;
  endfunction

  // Accept monitor and compare process, both evaluated away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (in_valid[d] && in_ready[d])
          q[d].push_back(model(d == 1, int_in[d], is_signed, rm));
        if (hold_v[d]) begin
          check("stall_valid", 64'(ov[d]), 64'd1);
          check("stall_fp_stable", fp[d], hold_fp[d]);
          check("stall_ff_stable", 64'(ff[d]), 64'(hold_ff[d]));
        end
        if (ov[d]) begin
          if (out_ready) begin
            hold_v[d] = 1'b0;
            if (q[d].size() == 0) begin
              fail("unexpected_output");
            end else begin
              e = q[d].pop_front();
              check(d == 0 ? "fp_out64" : "fp_out32", fp[d], e.res);
              check(d == 0 ? "fflags64" : "fflags32", 64'(ff[d]), {59'd0, 4'd0, e.nx});
            end
          end else begin
            hold_v[d]  = 1'b1;
            hold_fp[d] = fp[d];
            hold_ff[d] = ff[d];
          end
        end else begin
          hold_v[d] = 1'b0;
          check("idle_fp_zero", fp[d], 64'd0);
          check("idle_ff_zero", 64'(ff[d]), 64'd0);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the operand is taken.
  task automatic send(input int d, input logic [63:0] v, input bit sgn, input logic [2:0] m);
    int budget;
    int_in[d]   = v;
    is_signed   = sgn;
    rm          = m;
    in_valid[d] = 1'b1;
    budget      = 0;
    @(negedge clk);
    while (!in_ready[d] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) fail("accept_timeout");
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int budget;
    out_ready = 1'b1;
    budget    = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || ov[0] || ov[1]) && budget < 40) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 40) fail("drain_timeout");
  endtask

  // Edges from driving an operand into an empty, unstalled pipe until out_valid.
  task automatic measure(input int d, input logic [63:0] v, input bit sgn, input logic [2:0] m);
    int lat;
    int_in[d]   = v;
    is_signed   = sgn;
    rm          = m;
    in_valid[d] = 1'b1;
    lat         = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      lat++;
    end while (!ov[d] && lat < 10);
    check("latency", 64'(lat), 64'd3);
  endtask

  vec_t        dir[$];
  exp_t        r;
  logic [63:0] rv;
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n       = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    int_in[0]   = '0;
    int_in[1]   = '0;
    is_signed   = 1'b0;
    rm          = 3'd0;
    out_ready   = 1'b1;

    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_out_valid", 64'(ov[d]), 64'd0);
      check("reset_in_ready", 64'(in_ready[d]), 64'd1);
      check("reset_fp_out", fp[d], 64'd0);
      check("reset_fflags", 64'(ff[d]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hand-computed values pinning the model.
    r = model(0, 64'd1, 1, 3'd0);
    check("pin_one", r.res, 64'h3FF0_0000_0000_0000);
    check("pin_one_nx", 64'(r.nx), 64'd0);
    r = model(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3'd0);
    check("pin_minus_one", r.res, 64'hBFF0_0000_0000_0000);
    r = model(0, 64'h0020_0000_0000_0001, 1, 3'd0);
    check("pin_2p53p1_rne", r.res, 64'h4340_0000_0000_0000);
    check("pin_2p53p1_nx", 64'(r.nx), 64'd1);
    r = model(0, 64'h0020_0000_0000_0001, 1, 3'd3);
    check("pin_2p53p1_rup", r.res, 64'h4340_0000_0000_0001);
    r = model(0, 64'h0020_0000_0000_0001, 1, 3'd1);
    check("pin_2p53p1_rtz", r.res, 64'h4340_0000_0000_0000);
    r = model(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'd0);
    check("pin_umax_rne", r.res, 64'h43F0_0000_0000_0000);
    check("pin_umax_nx", 64'(r.nx), 64'd1);
    r = model(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'd1);
    check("pin_umax_rtz", r.res, 64'h43EF_FFFF_FFFF_FFFF);
    r = model(0, 64'h8000_0000_0000_0000, 1, 3'd0);
    check("pin_smin", r.res, 64'hC3E0_0000_0000_0000);
    check("pin_smin_nx", 64'(r.nx), 64'd0);
    r = model(1, 64'h0100_0001, 1, 3'd0);
    check("pin32_rne", r.res, 64'h4B80_0000);
    check("pin32_rne_nx", 64'(r.nx), 64'd1);
    r = model(1, 64'hFEFF_FFFF, 1, 3'd2);
    check("pin32_rdn", r.res, 64'hCB80_0001);

    // Directed operands through both instances, back to back.
    dir.push_back('{0, 64'd1, 1'b1, 3'd0});
    dir.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0});
    dir.push_back('{0, 64'h0020_0000_0000_0001, 1'b1, 3'd0});
    dir.push_back('{0, 64'h0020_0000_0000_0001, 1'b1, 3'd3});
    dir.push_back('{0, 64'h0020_0000_0000_0001, 1'b1, 3'd1});
    dir.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0});
    dir.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd1});
    dir.push_back('{0, 64'h8000_0000_0000_0000, 1'b1, 3'd0});
    dir.push_back('{1, 64'h0100_0001, 1'b1, 3'd0});
    dir.push_back('{1, 64'hFEFF_FFFF, 1'b1, 3'd2});
    dir.push_back('{1, 64'h8000_0000, 1'b1, 3'd4});
    dir.push_back('{1, 64'hFFFF_FFFF, 1'b0, 3'd3});
    for (int k = 0; k < 8; k++) begin
      dir.push_back('{0, 64'd0, 1'b1, 3'(k)});
      dir.push_back('{1, 64'd0, 1'b0, 3'(k)});
    end
    foreach (dir[i]) send(dir[i].d, dir[i].v, dir[i].sgn, dir[i].m);

    // Random operands with varied magnitudes, every rounding mode.
    for (int i = 0; i < 40; i++) begin
      rv = {$urandom, $urandom} >> $urandom_range(0, 63);
      send(i % 2, rv, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    drain();

    measure(0, 64'd12345, 1'b1, 3'd0);
    drain();

    // Backpressure: six back-to-back operands while out_ready toggles.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(0, 64'h0000_0F00_0000_0000 + 64'(i * 3) + 64'h0030_0000_0000_0001,
               1'b1, 3'(i % 5));
      end
      begin
        for (int k = 0; k < 24; k++) begin
          out_ready = pat[k % 4];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight.
    send(0, 64'd7, 1'b1, 3'd0);
    send(0, 64'd8, 1'b1, 3'd0);
    send(0, 64'd9, 1'b1, 3'd0);
    check("inflight_valid", 64'(ov[0]), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", 64'(ov[0]), 64'd0);
    check("async_reset_fp", fp[0], 64'd0);
    q[0].delete();
    q[1].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check("no_stale_result", 64'(ov[0]), 64'd0);
      @(posedge clk);
      #1;
    end
    measure(0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 3'd2);
    drain();

    check("leftover_q64", 64'(q[0].size()), 64'd0);
    check("leftover_q32", 64'(q[1].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
